// File: rtl/adpll_pkg.sv
// Shared encodings for the ADPLL TX serializer: operation modes and FSM states.
// PREAMBLE state exists only when ADPLL_TX_PREAMBLE_EN is defined.
package adpll_pkg;

  typedef enum logic [1:0] {
    MODE_PD   = 2'd0,
    MODE_TEST = 2'd1,
    MODE_RX   = 2'd2,
    MODE_TX   = 2'd3
  } adpll_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
`ifdef ADPLL_TX_PREAMBLE_EN
    ST_PREAMBLE  = 3'd2,
`endif
    ST_SEND      = 3'd3,
    ST_WAIT_DATA = 3'd4
  } tx_state_e;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;

endpackage

// File: rtl/adpll_tx_fifo.sv
// Byte FIFO feeding the TX serializer; flush has priority over push/pop.
// Pointers and count are reset, storage is not.
module adpll_tx_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/adpll_tx_ser.sv
// ADPLL TX serializer: FIFO bytes shifted out LSB first as BIT_CYCLES-long symbols.
// Define ADPLL_TX_PREAMBLE_EN to prepend an 8-symbol 0x55 preamble to each burst.
module adpll_tx_ser
  import adpll_pkg::*;
#(
  parameter int BIT_CYCLES = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] adpll_mode,
  input  logic       channel_lock,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       data_mod,
  output logic       sym_strobe,
  output logic       tx_active,
  output logic       underrun
);

  localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);

  tx_state_e        state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [2:0]       bit_idx, bit_nx;
  logic [7:0]       shreg, shreg_nx;
  logic             underrun_nx;
  logic             armed, boundary, counting;
  logic             fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [7:0]       fifo_head;

  adpll_tx_fifo #(.DEPTH(FIFO_DEPTH), .DATA_W(8)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .wdata (byte_in),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign armed      = en & (adpll_mode == MODE_TX);
  assign boundary   = (cnt == CNT_LAST);
  // Gated by rst so the handshake drops the instant reset asserts.
  assign byte_ready = rst & armed & ~fifo_full;
  assign fifo_push  = byte_valid & byte_ready;

  always_comb begin
    tx_active = (state == ST_SEND);
`ifdef ADPLL_TX_PREAMBLE_EN
    tx_active = tx_active | (state == ST_PREAMBLE);
`endif
    counting = tx_active | (state == ST_WAIT_DATA);
  end

  assign data_mod   = tx_active & shreg[0];
  assign sym_strobe = counting & boundary;

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    bit_nx      = bit_idx;
    shreg_nx    = shreg;
    underrun_nx = underrun;
    fifo_pop    = 1'b0;
    fifo_flush  = 1'b0;
    if (!armed) begin
      state_nx    = ST_IDLE;
      cnt_nx      = '0;
      bit_nx      = '0;
      underrun_nx = 1'b0;
      fifo_flush  = 1'b1;
    end else begin
      case (state)
        ST_IDLE: state_nx = ST_WAIT_LOCK;
        ST_WAIT_LOCK: begin
          if (channel_lock && !fifo_empty) begin
            cnt_nx = '0;
            bit_nx = '0;
`ifdef ADPLL_TX_PREAMBLE_EN
            state_nx = ST_PREAMBLE;
            shreg_nx = PREAMBLE_BYTE;
`else
            state_nx = ST_SEND;
            shreg_nx = fifo_head;
            fifo_pop = 1'b1;
`endif
          end
        end
        default: begin
          if (!counting) begin
            state_nx = ST_IDLE;
          end else if (!channel_lock) begin
            // Byte in flight is abandoned; queued bytes stay for the relock.
            state_nx = ST_WAIT_LOCK;
            cnt_nx   = '0;
            bit_nx   = '0;
          end else if (!boundary) begin
            cnt_nx = cnt + CNT_W'(1);
          end else begin
            cnt_nx = '0;
            if (state == ST_WAIT_DATA || bit_idx == 3'd7) begin
              bit_nx = '0;
              if (!fifo_empty) begin
                state_nx = ST_SEND;
                shreg_nx = fifo_head;
                fifo_pop = 1'b1;
              end else begin
                state_nx    = ST_WAIT_DATA;
                underrun_nx = 1'b1;
              end
            end else begin
              bit_nx   = bit_idx + 3'd1;
              shreg_nx = {1'b0, shreg[7:1]};
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      underrun <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      bit_idx  <= bit_nx;
      underrun <= underrun_nx;
    end
  end

  always_ff @(posedge clk) begin
    shreg <= shreg_nx;
  end

endmodule
